board_scorer: RTL and testbench

Avalon-MM accelerator that reads back the contiguous line of candidate boards written to SDRAM by the piece move-generator blocks, computes a signed material score for each board, writes each score to an output array, and reports the best board index to the CPU. It uses the same CPU-facing slave and SDRAM-facing master interfaces as the move generators, and acts as the reader for their output.

---
 rtl/board_scorer.sv | 204 ++++++++++++++++++++
 tb/tb_board_scorer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_scorer.sv
// board_scorer: walks a contiguous line of 64-square boards in SDRAM, sums a
// signed material score per board, writes each score to a destination array
// and keeps the best (max or min) board for the CPU to read back.
//
// Handshakes: a master strobe (read or write) together with its address and
// data is registered and held unchanged until a cycle in which
// master_waitrequest is low; that cycle completes the transfer. A CPU access
// is accepted only in a cycle where slave_waitrequest is low, and
// slave_readdata is valid in that same cycle.
`timescale 1ns/1ps

module board_scorer (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_SCORE,
        S_CMP,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        src;
    logic [31:0]        dest;
    logic [7:0]         nboards;
    logic               mode;
    logic [7:0]         board;
    logic [5:0]         sq;
    logic signed [31:0] acc;
    logic [31:0]        best_idx;
    logic signed [31:0] best_score;

    logic signed [31:0] square_value;
    logic signed [31:0] acc_next;
    logic               better;
    logic               unused_readdata_bits;

    // Signed material value of one piece code; unknown magnitudes score 0.
    function automatic logic signed [31:0] piece_value(input logic [7:0] code);
        case (code)
            8'h01:   return  32'sd100;
            8'hFF:   return -32'sd100;
            8'h02:   return  32'sd320;
            8'hFE:   return -32'sd320;
            8'h03:   return  32'sd330;
            8'hFD:   return -32'sd330;
            8'h04:   return  32'sd500;
            8'hFC:   return -32'sd500;
            8'h05:   return  32'sd900;
            8'hFB:   return -32'sd900;
            8'h06:   return  32'sd20000;
            8'hFA:   return -32'sd20000;
            default: return  32'sd0;
        endcase
    endfunction

    // Only the low byte of each square word carries the piece code.
    assign unused_readdata_bits = ^master_readdata[31:8];

    assign square_value = piece_value(master_readdata[7:0]);
    assign acc_next     = acc + square_value;
    // Board 0 always seeds the best; later boards must be strictly better,
    // so ties keep the lower index.
    assign better = (board == 8'd0) ||
                    (mode ? (acc < best_score) : (acc > best_score));

    // CPU result mux; addresses other than 0 and 1 read as zero.
    always_comb begin
        slave_readdata = 32'd0;
        case (slave_address)
            4'd0:    slave_readdata = best_idx;
            4'd1:    slave_readdata = best_score;
            default: slave_readdata = 32'd0;
        endcase
    end

    // Job sequencer with registered bus outputs; the square address is
    // src + 64*board + sq, i.e. src plus the concatenation {board, sq}.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            slave_waitrequest <= 1'b1;
            master_read       <= 1'b0;
            master_write      <= 1'b0;
            master_address    <= 32'd0;
            master_writedata  <= 32'd0;
            src               <= 32'd0;
            dest              <= 32'd0;
            nboards           <= 8'd0;
            mode              <= 1'b0;
            board             <= 8'd0;
            sq                <= 6'd0;
            acc               <= 32'sd0;
            best_idx          <= 32'd0;
            best_score        <= 32'sd0;
        end else begin
            case (state)
                S_IDLE: begin
                    slave_waitrequest <= 1'b0;
                    if (slave_write && !slave_waitrequest) begin
                        case (slave_address)
                            4'd1: src     <= slave_writedata;
                            4'd2: dest    <= slave_writedata;
                            4'd3: nboards <= slave_writedata[7:0];
                            4'd4: mode    <= slave_writedata[0];
                            4'd0: begin
                                board <= 8'd0;
                                sq    <= 6'd0;
                                acc   <= 32'sd0;
                                if (nboards == 8'd0) begin
                                    best_idx   <= 32'hFFFF_FFFF;
                                    best_score <= 32'sd0;
                                    state      <= S_DONE;
                                end else begin
                                    slave_waitrequest <= 1'b1;
                                    master_read       <= 1'b1;
                                    master_address    <= src;
                                    state             <= S_RD_REQ;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RD_REQ: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        acc <= acc_next;
                        sq  <= sq + 6'd1;
                        if (sq == 6'd63) begin
                            master_write     <= 1'b1;
                            master_address   <= dest + {24'd0, board};
                            master_writedata <= acc_next;
                            state            <= S_WR_SCORE;
                        end else begin
                            master_read    <= 1'b1;
                            master_address <= src + {18'd0, board, sq + 6'd1};
                            state          <= S_RD_REQ;
                        end
                    end
                end
                S_WR_SCORE: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        state        <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (better) begin
                        best_idx   <= {24'd0, board};
                        best_score <= acc;
                    end
                    board <= board + 8'd1;
                    acc   <= 32'sd0;
                    sq    <= 6'd0;
                    if ((board + 8'd1) == nboards) begin
                        slave_waitrequest <= 1'b0;
                        state             <= S_DONE;
                    end else begin
                        master_read    <= 1'b1;
                        master_address <= src + {18'd0, board + 8'd1, 6'd0};
                        state          <= S_RD_REQ;
                    end
                end
                S_DONE: begin
                    slave_waitrequest <= 1'b0;
                    if (slave_read && !slave_waitrequest &&
                        (slave_address == 4'd0 || slave_address == 4'd1)) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    slave_waitrequest <= 1'b1;
                    master_read       <= 1'b0;
                    master_write      <= 1'b0;
                    state             <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_scorer.sv
// Testbench for board_scorer: SDRAM responder with optional random stalls,
// expected-score queue for the write stream, and a material-count model.
`timescale 1ns/1ps

module tb_board_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = 4'd0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = 32'd0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = 32'd0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    board_scorer dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];

    int          rd_count = 0;
    int          wr_count = 0;
    bit          rand_wait = 1'b0;
    int          rdv_cd = -1;
    logic [31:0] rdv_addr = 32'd0;
    bit          acc_pend = 1'b0;
    logic [31:0] acc_addr = 32'd0;
    bit          stall_rd = 1'b0;
    bit          stall_wr = 1'b0;
    logic [31:0] stall_addr = 32'd0;
    logic [31:0] stall_data = 32'd0;

    logic [31:0] exp_best_idx;
    logic [31:0] exp_best_score;
    int          job_n;
    int          rd0;
    int          wr0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- SDRAM responder ----------------
    // Runs on the falling edge: answers accepted reads after 0-3 cycles,
    // picks this cycle's waitrequest, and logs handshakes for the next edge.
    always @(negedge clk) begin
        if (acc_pend) begin
            rdv_cd   = rand_wait ? int'($urandom_range(0, 3)) : 0;
            rdv_addr = acc_addr;
            acc_pend = 1'b0;
        end
        if (rdv_cd == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = mem.exists(rdv_addr) ? mem[rdv_addr] : 32'd0;
            rdv_cd               = -1;
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom();
            if (rdv_cd > 0) rdv_cd--;
        end
        master_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
        stall_rd   = !rst && master_read && master_waitrequest;
        stall_wr   = !rst && master_write && master_waitrequest;
        stall_addr = master_address;
        stall_data = master_writedata;
        if (!rst && master_read && !master_waitrequest) begin
            acc_pend = 1'b1;
            acc_addr = master_address;
            rd_count++;
        end
        if (!rst && master_write && !master_waitrequest) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_write: observed write %h at %h, expected none",
                       master_writedata, master_address);
            end else begin
                check("score_data", master_writedata, exp_q.pop_front());
                check("score_addr", master_address, exp_addr_q.pop_front());
            end
            mem[master_address] = master_writedata;
        end
    end

    // Stalled strobes must hold strobe, address and data into the next cycle.
    always @(posedge clk) begin
        #1;
        if (!rst && stall_rd) begin
            check("hold_rd_strobe", master_read, 32'd1);
            check("hold_rd_addr", master_address, stall_addr);
        end
        if (!rst && stall_wr) begin
            check("hold_wr_strobe", master_write, 32'd1);
            check("hold_wr_addr", master_address, stall_addr);
            check("hold_wr_data", master_writedata, stall_data);
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_value(input logic [31:0] word);
        int vals[0:6];
        int c;
        int m;
        int v;
        vals = '{0, 100, 320, 330, 500, 900, 20000};
        c = int'($signed(word[7:0]));
        m = (c < 0) ? -c : c;
        v = (m <= 6) ? vals[m] : 0;
        return (c < 0) ? -v : v;
    endfunction

    function automatic int model_board(input logic [31:0] base, input int b);
        int sum = 0;
        for (int s = 0; s < 64; s++) begin
            logic [31:0] a;
            a = base + 32'(64 * b + s);
            sum += model_value(mem.exists(a) ? mem[a] : 32'd0);
        end
        return sum;
    endfunction

    // ---------------- board builders ----------------
    function automatic int start_code(input int s);
        int back[0:7];
        int rank;
        int file;
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        rank = s / 8;
        file = s % 8;
        if (rank == 0) return back[file];
        if (rank == 1) return 1;
        if (rank == 6) return -1;
        if (rank == 7) return -back[file];
        return 0;
    endfunction

    task automatic put_square(input logic [31:0] addr, input int code);
        logic [31:0] w;
        w = $urandom();
        w[7:0] = code[7:0];
        mem[addr] = w;
    endtask

    task automatic put_start(input logic [31:0] base, input int b, input bit drop_bq);
        for (int s = 0; s < 64; s++)
            put_square(base + 32'(64 * b + s), (drop_bq && s == 59) ? 0 : start_code(s));
    endtask

    task automatic put_random(input logic [31:0] base, input int b);
        for (int s = 0; s < 64; s++) begin
            int r;
            int code;
            r = int'($urandom_range(0, 19));
            code = (r < 17) ? r - 8 : (r == 17) ? -128 : (r == 18) ? 127 : 7;
            put_square(base + 32'(64 * b + s), code);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic slave_wr(input logic [3:0] addr, input logic [31:0] data);
        int n = 0;
        slave_write     = 1'b1;
        slave_address   = addr;
        slave_writedata = data;
        while (slave_waitrequest && n < 1000) begin
            tick();
            n++;
        end
        check("slave_wr_timeout", 32'(n < 1000), 32'd1);
        tick();
        slave_write = 1'b0;
    endtask

    task automatic slave_rd(input logic [3:0] addr, output logic [31:0] data);
        int n = 0;
        slave_read    = 1'b1;
        slave_address = addr;
        while (slave_waitrequest && n < 1000) begin
            tick();
            n++;
        end
        check("slave_rd_timeout", 32'(n < 1000), 32'd1);
        #1;
        data = slave_readdata;
        tick();
        slave_read = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] src, input logic [31:0] dest,
                             input int n, input bit mode);
        int scores[$];
        int ext;
        for (int b = 0; b < n; b++) begin
            scores.push_back(model_board(src, b));
            exp_q.push_back(32'(scores[b]));
            exp_addr_q.push_back(dest + 32'(b));
        end
        if (n == 0) begin
            exp_best_idx   = 32'hFFFF_FFFF;
            exp_best_score = 32'd0;
        end else begin
            ext = scores[0];
            foreach (scores[b])
                if (mode ? scores[b] < ext : scores[b] > ext) ext = scores[b];
            exp_best_score = 32'(ext);
            exp_best_idx   = 32'd0;
            for (int b = n - 1; b >= 0; b--)
                if (scores[b] == ext) exp_best_idx = 32'(b);
        end
        job_n = n;
        rd0   = rd_count;
        wr0   = wr_count;
        slave_wr(4'd1, src);
        slave_wr(4'd2, dest);
        slave_wr(4'd3, 32'(n));
        slave_wr(4'd4, {31'd0, mode});
        slave_wr(4'd0, 32'd0);
    endtask

    task automatic finish_job(input string tag);
        int cyc = 0;
        logic [31:0] rd_val;
        while (slave_waitrequest && cyc < 30000) begin
            tick();
            cyc++;
        end
        check({tag, "_done_timeout"}, 32'(cyc < 30000), 32'd1);
        check({tag, "_reads"}, 32'(rd_count - rd0), 32'(64 * job_n));
        check({tag, "_writes"}, 32'(wr_count - wr0), 32'(job_n));
        check({tag, "_pending_scores"}, 32'(exp_q.size()), 32'd0);
        slave_rd(4'd0, rd_val);
        check({tag, "_best_idx"}, rd_val, exp_best_idx);
        slave_rd(4'd1, rd_val);
        check({tag, "_best_score"}, rd_val, exp_best_score);
        slave_rd(4'd5, rd_val);
        check({tag, "_other_addr"}, rd_val, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [31:0] src3;
        bit          m;
        int          guard;

        // reset held 3 cycles
        rst = 1'b1;
        tick(3);
        check("rst_slave_waitrequest", slave_waitrequest, 32'd1);
        check("rst_master_read", master_read, 32'd0);
        check("rst_master_write", master_write, 32'd0);
        check("rst_master_address", master_address, 32'd0);
        check("rst_master_writedata", master_writedata, 32'd0);
        check("rst_slave_readdata", slave_readdata, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_waitrequest_drop", slave_waitrequest, 32'd0);

        // single start position
        put_start(32'h1000, 0, 1'b0);
        start_job(32'h1000, 32'h8000, 1, 1'b0);
        finish_job("start1");
        check("start1_dest0", mem[32'h8000], 32'd0);

        // three boards, middle one missing the black queen
        src3 = 32'h2000;
        put_start(src3, 0, 1'b0);
        put_start(src3, 1, 1'b1);
        put_start(src3, 2, 1'b0);
        start_job(src3, 32'h9000, 3, 1'b0);
        finish_job("three_max");
        check("three_max_score1", mem[32'h9001], 32'd900);
        check("three_max_score2", mem[32'h9002], 32'd0);

        start_job(src3, 32'h9100, 3, 1'b1);
        finish_job("three_min");

        // same boards under random stalls
        rand_wait = 1'b1;
        start_job(src3, 32'h9200, 3, 1'b0);
        finish_job("three_stall");
        check("three_stall_score1", mem[32'h9201], 32'd900);

        // random boards, random mode
        for (int j = 0; j < 3; j++) begin
            for (int b = 0; b < 4; b++) put_random(32'h4000, b);
            m = 1'($urandom_range(0, 1));
            start_job(32'h4000, 32'hA000 + 32'(16 * j), 4, m);
            finish_job("random");
        end

        // empty job
        rand_wait = 1'b0;
        start_job(32'h1000, 32'hB000, 0, 1'b0);
        finish_job("empty");

        // abort in the middle of board index 1, then a fresh job
        rand_wait = 1'b1;
        for (int b = 0; b < 3; b++) put_random(32'h5000, b);
        start_job(32'h5000, 32'hC000, 3, 1'b0);
        guard = 0;
        while (rd_count < rd0 + 64 + 20 && guard < 20000) begin
            tick();
            guard++;
        end
        check("abort_reach_timeout", 32'(guard < 20000), 32'd1);
        rst = 1'b1;
        tick(2);
        check("abort_waitrequest", slave_waitrequest, 32'd1);
        check("abort_master_read", master_read, 32'd0);
        check("abort_master_write", master_write, 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        rst = 1'b0;
        rd0 = rd_count;
        wr0 = wr_count;
        tick(6);
        check("abort_no_reads", 32'(rd_count - rd0), 32'd0);
        check("abort_no_writes", 32'(wr_count - wr0), 32'd0);
        check("abort_idle_waitrequest", slave_waitrequest, 32'd0);
        start_job(32'h5000, 32'hC100, 3, 1'b1);
        finish_job("after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a wait outside the bounded loops never completes.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
